// File: rtl/sr_fetch.sv
// rtl/sr_fetch.sv - schoolRISCV fetch stage: PC, instruction memory request, response buffer.
module sr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic [31:0] imData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetchPc;
    logic [31:0]   inflightPc;
    logic          inflight;
    logic          kill;
    logic [31:0]   instrMem [DEPTH];
    logic [31:0]   pcMem    [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic          pop;
    logic          push;

    assign instrValid = (count != '0);
    assign pop        = instrValid && instrReady;
    assign push       = inflight && !kill && !redirect && !rst;

    // Buffer occupancy once this cycle's pop and the outstanding response settle.
    assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imReq = !rst && !redirect && (occ < (CW+1)'(DEPTH));
    assign imAddr = fetchPc;

    assign instr   = instrValid ? instrMem[rdPtr] : NOP;
    assign instrPc = instrValid ? pcMem[rdPtr]    : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= imData;
            pcMem[wrPtr]    <= inflightPc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= 32'h0000_0000;
            kill       <= 1'b0;
            count      <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
        end else if (redirect) begin
            fetchPc  <= {redirectPc[31:2], 2'b00};
            inflight <= 1'b0;
            kill     <= imReq;
            count    <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
        end else begin
            kill <= 1'b0;
            if (imReq) begin
                fetchPc    <= fetchPc + 32'd4;
                inflight   <= 1'b1;
                inflightPc <= fetchPc;
            end else begin
                inflight <= 1'b0;
            end
            if (push)
                wrPtr <= wrPtr + AW'(1);
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_sr_fetch.sv
// tb/tb_sr_fetch.sv - directed self-checking bench for sr_fetch.
module tb_sr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imReq, imReq2;
    logic [31:0] imAddr, imAddr2;
    logic [31:0] imData = 32'h0, imData2 = 32'h0;
    logic        redirect, redirect2;
    logic [31:0] redirectPc, redirectPc2;
    logic        instrValid, instrValid2;
    logic        instrReady, instrReady2;
    logic [31:0] instr, instr2;
    logic [31:0] instrPc, instrPc2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imReq(imReq), .imAddr(imAddr), .imData(imData),
        .redirect(redirect), .redirectPc(redirectPc), .instrValid(instrValid),
        .instrReady(instrReady), .instr(instr), .instrPc(instrPc)
    );

    sr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imReq(imReq2), .imAddr(imAddr2), .imData(imData2),
        .redirect(redirect2), .redirectPc(redirectPc2), .instrValid(instrValid2),
        .instrReady(instrReady2), .instr(instr2), .instrPc(instrPc2)
    );

    // One-cycle-latency instruction memory: word = A000_0000 | address.
    always @(posedge clk) begin
        if (imReq)
            imData <= 32'hA000_0000 | imAddr;
        if (imReq2)
            imData2 <= 32'hA000_0000 | imAddr2;
    end

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        redirectPc = 32'h0;
        instrReady = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        instrReady = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (imReq !== 1'b0) begin n_fail++; $display("FAIL reset_imReq: got %b want 0", imReq); end
        n_cmp++;
        if (imAddr !== 32'h0) begin n_fail++; $display("FAIL reset_imAddr: got %h want 00000000", imAddr); end
        n_cmp++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instrValid); end
        n_cmp++;
        if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        n_cmp++;
        if (instrPc !== 32'h0) begin n_fail++; $display("FAIL reset_instrPc: got %h want 00000000", instrPc); end
        n_cmp++;
        if (imAddr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_imAddr_wrap: got %h want fffffff8", imAddr2); end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        n_cmp++;
        if (imReq !== 1'b1 || imAddr !== 32'h0) begin
            n_fail++; $display("FAIL stream_c0_req: got req=%b addr=%h want req=1 addr=00000000", imReq, imAddr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", instrValid); end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b1 || instr !== 32'hA000_0000 || instrPc !== 32'h0) begin
            n_fail++; $display("FAIL stream_c2: got v=%b instr=%h pc=%h want v=1 instr=a0000000 pc=00000000", instrValid, instr, instrPc);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (instrValid !== 1'b1 || instrPc !== 32'(4 * i) || instr !== (32'hA000_0000 | 32'(4 * i))) begin
                n_fail++; $display("FAIL stream_c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", i + 2, instrValid, instrPc, instr, 4 * i);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        do_reset(1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (instrValid !== 1'b1 || instrPc !== 32'h0 || instr !== 32'hA000_0000 || imReq !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b pc=%h instr=%h req=%b want v=1 pc=0 instr=a0000000 req=0", i, instrValid, instrPc, instr, imReq);
            end
            @(negedge clk); #1;
        end
        instrReady = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 30 && exp_pc < 32'd24; i++) begin
            #1;
            if (instrValid) begin
                n_cmp++;
                if (instrPc !== exp_pc) begin n_fail++; $display("FAIL bp_release_pc: got %h want %h", instrPc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_pc !== 32'd24) begin n_fail++; $display("FAIL bp_release_count: got %0d want 6", exp_pc / 4); end
    endtask

    task automatic test_redirect;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirectPc = 32'h0000_0103;
        #1;
        n_cmp++;
        if (imReq !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %b want 0", imReq); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_cmp++;
        if (instrValid !== 1'b0 || imReq !== 1'b1 || imAddr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL redir_n1: got v=%b req=%b addr=%h want v=0 req=1 addr=00000100", instrValid, imReq, imAddr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL redir_n2_valid: got %b pc=%h want 0", instrValid, instrPc); end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0100 || instr !== 32'hA000_0100) begin
            n_fail++; $display("FAIL redir_n3: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=a0000100", instrValid, instrPc, instr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0104) begin
            n_fail++; $display("FAIL redir_n4: got v=%b pc=%h want v=1 pc=00000104", instrValid, instrPc);
        end
    endtask

    task automatic test_redirect_with_pop;
        int got;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        redirect = 1'b1;
        redirectPc = 32'h0000_0200;
        #1;
        n_cmp++;
        if (instrValid !== 1'b1 || instrPc !== 32'h8) begin
            n_fail++; $display("FAIL rpop_head: got v=%b pc=%h want v=1 pc=00000008", instrValid, instrPc);
        end
        @(negedge clk);
        redirect = 1'b0;
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            #1;
            if (instrValid) begin
                got = 1;
                n_cmp++;
                if (instrPc !== 32'h0000_0200) begin n_fail++; $display("FAIL rpop_next_pc: got %h want 00000200", instrPc); end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (got != 1) begin n_fail++; $display("FAIL rpop_timeout: got %0d deliveries want 1", got); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pcs [3];
        int got;
        exp_pcs[0] = 32'hFFFF_FFF8;
        exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000;
        do_reset(1'b1);
        got = 0;
        for (int i = 0; i < 12 && got < 3; i++) begin
            if (instrValid2) begin
                n_cmp++;
                if (instrPc2 !== exp_pcs[got]) begin n_fail++; $display("FAIL wrap_pc%0d: got %h want %h", got, instrPc2, exp_pcs[got]); end
                got++;
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (got != 3) begin n_fail++; $display("FAIL wrap_timeout: got %0d deliveries want 3", got); end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imReq !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b want 0", imReq); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (instrValid !== 1'b0 || instr !== 32'h0000_0013 || instrPc !== 32'h0) begin
            n_fail++; $display("FAIL rmid_out: got v=%b instr=%h pc=%h want v=0 instr=00000013 pc=0", instrValid, instr, instrPc);
        end
        n_cmp++;
        if (imReq !== 1'b1 || imAddr !== 32'h0) begin
            n_fail++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=00000000", imReq, imAddr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale: got v=%b pc=%h want v=0", instrValid, instrPc); end
        @(negedge clk); #1;
        n_cmp++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
            n_fail++; $display("FAIL rmid_first: got v=%b pc=%h want v=1 pc=00000000", instrValid, instrPc);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirectPc = 32'h0;
        instrReady = 1'b0;
        redirect2 = 1'b0;
        redirectPc2 = 32'h0;
        instrReady2 = 1'b1;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_redirect_with_pop;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
